// File: rtl/rho_rotate_if.sv
// Page-stream bundle between the theta stage, the rho rotator and its consumer.
// master drives pages in and takes rotated pages out; slave is the rotator.
interface rho_rotate_if;
  logic        start;
  logic        in_valid;
  logic [24:0] In;
  logic        Ready;
  logic        out_valid;
  logic [24:0] Out;
  logic [5:0]  page_index;
  logic        Done;

  modport master (
    output start, in_valid, In,
    input  Ready, out_valid, Out, page_index, Done
  );

  modport slave (
    input  start, in_valid, In,
    output Ready, out_valid, Out, page_index, Done
  );
endinterface

// File: rtl/rho_rotate.sv
// Keccak rho step: buffers 64 slice-pages of 25 lanes, then replays them with
// each lane rotated along z by its fixed offset.
module rho_rotate (
  input  logic         clk,
  input  logic         reset,
  rho_rotate_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ROT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [24:0] r_page [64];
  logic [24:0] w_out;
  logic [5:0]  w_src;

  // Rho offsets indexed by lane l = x + 5y.
  function automatic logic [5:0] rho_off(input int l);
    case (l)
      0:  rho_off = 6'd0;
      1:  rho_off = 6'd1;
      2:  rho_off = 6'd62;
      3:  rho_off = 6'd28;
      4:  rho_off = 6'd27;
      5:  rho_off = 6'd36;
      6:  rho_off = 6'd44;
      7:  rho_off = 6'd6;
      8:  rho_off = 6'd55;
      9:  rho_off = 6'd20;
      10: rho_off = 6'd3;
      11: rho_off = 6'd10;
      12: rho_off = 6'd43;
      13: rho_off = 6'd25;
      14: rho_off = 6'd39;
      15: rho_off = 6'd41;
      16: rho_off = 6'd45;
      17: rho_off = 6'd15;
      18: rho_off = 6'd21;
      19: rho_off = 6'd8;
      20: rho_off = 6'd18;
      21: rho_off = 6'd2;
      22: rho_off = 6'd61;
      23: rho_off = 6'd56;
      24: rho_off = 6'd14;
      default: rho_off = 6'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_LOAD;
            r_cnt   <= 6'd0;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd63) r_state <= S_ROT;
          end
        end
        S_ROT: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Page storage is data only; its contents after reset are irrelevant.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && bus.in_valid) r_page[r_cnt] <= bus.In;
  end

  // Output page z takes lane l from stored page (z - r_l) mod 64.
  always_comb begin
    w_out = '0;
    w_src = '0;
    for (int l = 0; l < 25; l++) begin
      w_src    = r_cnt - rho_off(l);
      w_out[l] = r_page[w_src][l];
    end
  end

  assign bus.Ready      = (r_state == S_IDLE);
  assign bus.out_valid  = (r_state == S_ROT);
  assign bus.Done       = (r_state == S_DONE);
  assign bus.page_index = r_cnt;
  assign bus.Out        = (r_state == S_ROT) ? w_out : 25'd0;

endmodule

// File: tb/tb_rho_rotate.sv
// Directed bench for rho_rotate: single-bit lane vectors, all-ones, random
// states against a forward rho model, stalls, ignored starts, reset abort.
module tb_rho_rotate;

  logic clk;
  logic reset;

  rho_rotate_if bus ();

  rho_rotate dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int R [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43,
                            25, 39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  typedef struct {
    int lane;
    int zin;
    int zout;
  } vec_t;

  int          n_cmp;
  int          n_fail;
  logic [24:0] st [64];
  logic [24:0] ex [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic build_model();
    int d;
    for (int z = 0; z < 64; z++) ex[z] = '0;
    for (int z = 0; z < 64; z++)
      for (int l = 0; l < 25; l++) begin
        d = (z + R[l]) % 64;
        ex[d][l] = st[z][l];
      end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge where
  // the first rotated page should be visible.
  task automatic load_state(input int mode);
    int  z;
    int  cyc;
    logic v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    z   = 0;
    cyc = 0;
    while (z < 64 && cyc < 400) begin
      chk($sformatf("load_idx z=%0d", z), 32'(bus.page_index), 32'(z));
      chk("load_ready", 32'(bus.Ready), 32'd0);
      chk("load_ovalid", 32'(bus.out_valid), 32'd0);
      v = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      bus.start    = (mode == 2) ? (cyc % 5 == 1) : 1'b0;
      bus.in_valid = v;
      bus.In       = v ? st[z] : ~st[z];
      @(negedge clk);
      if (v) z++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    bus.In       = '0;
    if (z < 64) chk("load_timeout", 32'(z), 32'd64);
    if (mode == 1) chk("stall_load_cycles", 32'(cyc), 32'd190);
  endtask

  task automatic rotate_check(input int mode, input int abort_at);
    for (int p = 0; p < 64; p++) begin
      chk($sformatf("rot_valid p=%0d", p), 32'(bus.out_valid), 32'd1);
      chk($sformatf("rot_idx p=%0d", p), 32'(bus.page_index), 32'(p));
      chk($sformatf("rot_out p=%0d", p), 32'(bus.Out), 32'(ex[p]));
      if (p == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_ovalid", 32'(bus.out_valid), 32'd0);
        chk("abort_out", 32'(bus.Out), 32'd0);
        chk("abort_ready", 32'(bus.Ready), 32'd1);
        chk("abort_idx", 32'(bus.page_index), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      bus.start = (mode == 2 && p < 60) ? (p % 7 == 3) : 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done_pulse", 32'(bus.Done), 32'd1);
    chk("done_ovalid", 32'(bus.out_valid), 32'd0);
    chk("done_out", 32'(bus.Out), 32'd0);
    chk("done_ready", 32'(bus.Ready), 32'd0);
    @(negedge clk);
    chk("idle_ready", 32'(bus.Ready), 32'd1);
    chk("idle_done", 32'(bus.Done), 32'd0);
  endtask

  task automatic random_state();
    for (int z = 0; z < 64; z++) st[z] = 25'($urandom);
  endtask

  initial begin
    vec_t vecs [8];
    vecs[0] = '{lane: 1,  zin: 0,  zout: 1};
    vecs[1] = '{lane: 2,  zin: 5,  zout: 3};
    vecs[2] = '{lane: 24, zin: 60, zout: 10};
    vecs[3] = '{lane: 0,  zin: 7,  zout: 7};
    vecs[4] = '{lane: 3,  zin: 63, zout: 27};
    vecs[5] = '{lane: 22, zin: 10, zout: 7};
    vecs[6] = '{lane: 5,  zin: 40, zout: 12};
    vecs[7] = '{lane: 12, zin: 30, zout: 9};

    n_cmp        = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.In       = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.Ready), 32'd1);
    chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", 32'(bus.Out), 32'd0);
    chk("rst_idx", 32'(bus.page_index), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single-bit vectors with hand-computed destination pages.
    for (int i = 0; i < 8; i++) begin
      for (int z = 0; z < 64; z++) begin
        st[z] = '0;
        ex[z] = '0;
      end
      st[vecs[i].zin][vecs[i].lane]  = 1'b1;
      ex[vecs[i].zout][vecs[i].lane] = 1'b1;
      load_state(0);
      rotate_check(0, -1);
    end

    for (int z = 0; z < 64; z++) begin
      st[z] = 25'h1FFFFFF;
      ex[z] = 25'h1FFFFFF;
    end
    load_state(0);
    rotate_check(0, -1);

    random_state();
    build_model();
    load_state(0);
    rotate_check(0, -1);

    random_state();
    build_model();
    load_state(1);
    rotate_check(0, -1);

    random_state();
    build_model();
    load_state(2);
    rotate_check(2, -1);

    random_state();
    build_model();
    load_state(0);
    rotate_check(0, 20);

    random_state();
    build_model();
    load_state(0);
    rotate_check(0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
